// File: rtl/reg_ctrl_seq.sv
// Multi-cycle instruction sequencer that drives a 4 x 9-bit register file and ALU.
// It fetches, decodes, executes and writes back one instruction at a time.
module reg_ctrl_seq #(
    parameter int unsigned     PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    output logic            o_imem_req,
    output logic [PC_W-1:0] o_imem_addr,
    input  logic            i_imem_ack,
    input  logic [8:0]      i_imem_data,
    output logic            o_rd_en,
    output logic [1:0]      o_rd0_addr,
    output logic [1:0]      o_rd1_addr,
    output logic            o_wr_en,
    output logic [1:0]      o_wr_addr,
    output logic [8:0]      o_wr_data,
    output logic [1:0]      o_alu_op,
    input  logic [8:0]      i_alu_result,
    output logic            o_halted,
    output logic [15:0]     o_instr_count
);

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExec,
        StWb,
        StHalt
    } state_e;

    state_e            r_state;
    state_e            w_state_nxt;
    logic [PC_W-1:0]   r_pc;
    logic [8:0]        r_ir;
    logic [8:0]        r_result;
    logic [15:0]       r_count;

    logic              w_fetch;
    logic              w_load_result;
    logic [8:0]        w_result_nxt;
    logic              w_retire;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= StFetch;
            r_pc     <= RESET_PC;
            r_ir     <= '0;
            r_result <= '0;
            r_count  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_fetch) begin
                r_ir <= i_imem_data;
                r_pc <= r_pc + PC_W'(1);
            end
            if (w_load_result) begin
                r_result <= w_result_nxt;
            end
            // Retired count saturates rather than wrapping.
            if (w_retire && (r_count != 16'hFFFF)) begin
                r_count <= r_count + 16'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_fetch       = 1'b0;
        w_load_result = 1'b0;
        w_result_nxt  = i_alu_result;
        w_retire      = 1'b0;
        o_imem_req    = 1'b0;
        o_rd_en       = 1'b0;
        o_wr_en       = 1'b0;
        o_halted      = 1'b0;
        unique case (r_state)
            StFetch: begin
                o_imem_req = 1'b1;
                if (i_imem_ack) begin
                    w_fetch     = 1'b1;
                    w_state_nxt = StDecode;
                end
            end
            StDecode: begin
                if (!r_ir[8]) begin
                    o_rd_en     = 1'b1;
                    w_state_nxt = StExec;
                end else begin
                    unique case (r_ir[7:6])
                        2'b00: begin
                            w_load_result = 1'b1;
                            w_result_nxt  = {{5{r_ir[3]}}, r_ir[3:0]};
                            w_state_nxt   = StWb;
                        end
                        2'b11: begin
                            w_retire    = 1'b1;
                            w_state_nxt = StHalt;
                        end
                        default: begin
                            w_retire    = 1'b1;
                            w_state_nxt = StFetch;
                        end
                    endcase
                end
            end
            StExec: begin
                w_load_result = 1'b1;
                w_state_nxt   = StWb;
            end
            StWb: begin
                o_wr_en     = 1'b1;
                w_retire    = 1'b1;
                w_state_nxt = StFetch;
            end
            StHalt: begin
                o_halted = 1'b1;
            end
            default: begin
                w_state_nxt = StFetch;
            end
        endcase
    end

    assign o_imem_addr   = r_pc;
    assign o_rd0_addr    = r_ir[3:2];
    assign o_rd1_addr    = r_ir[1:0];
    assign o_wr_addr     = r_ir[5:4];
    assign o_wr_data     = r_result;
    assign o_alu_op      = r_ir[7:6];
    assign o_instr_count = r_count;

endmodule
